dsp_mac_engine: RTL

- Parametrised successor to the team's single-slice DSP block: signed pre-adder, multiplier and post-adder/accumulator with configurable operand widths.
- Adds a valid/ready streaming interface with back-pressure, frame-based accumulation with automatic restart, and saturating output with overflow flagging.
- Sits between sample-stream producers (filters, correlators) and downstream FPGA logic.
- Fixed 3-stage pipeline: input/pre-add, multiply, post-add.

---
 rtl/dsp_mac_if.sv | 34 +++
 rtl/dsp_mac_engine.sv | 115 +++++++++++
 2 files changed

// File: rtl/dsp_mac_if.sv
// Streaming bus for dsp_mac_engine: sample input with valid/ready, result output with valid/ready.
// Widths must match the parameters of the engine instance attached to it.
interface dsp_mac_if #(
    parameter int A_WIDTH = 18,
    parameter int B_WIDTH = 18,
    parameter int C_WIDTH = 48,
    parameter int P_WIDTH = 48
);
    localparam int M_WIDTH = A_WIDTH + B_WIDTH + 1;

    logic                      in_valid;
    logic                      in_ready;
    logic signed [A_WIDTH-1:0] a;
    logic signed [B_WIDTH-1:0] b;
    logic signed [B_WIDTH-1:0] d;
    logic signed [C_WIDTH-1:0] c;
    logic [3:0]                mode;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [P_WIDTH-1:0] p;
    logic signed [M_WIDTH-1:0] m;
    logic                      frame_last;
    logic                      overflow;

    modport master (
        output in_valid, a, b, d, c, mode, out_ready,
        input  in_ready, out_valid, p, m, frame_last, overflow
    );

    modport slave (
        input  in_valid, a, b, d, c, mode, out_ready,
        output in_ready, out_valid, p, m, frame_last, overflow
    );
endinterface

// File: rtl/dsp_mac_engine.sv
// Three-stage signed pre-add / multiply / post-add MAC with frame accumulation,
// saturating or wrapping output, and valid/ready flow control on both sides.
module dsp_mac_engine #(
    parameter int A_WIDTH  = 18,
    parameter int B_WIDTH  = 18,
    parameter int C_WIDTH  = 48,
    parameter int P_WIDTH  = 48,
    parameter int ACC_LEN  = 16,
    parameter bit SATURATE = 1'b1
) (
    input logic     clk,
    input logic     rst,
    dsp_mac_if.slave bus
);
    localparam int STAGES = 3;
    localparam int M_WIDTH = A_WIDTH + B_WIDTH + 1;
    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);
    localparam logic signed [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic signed [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

    logic [STAGES:1] vld_q;
    logic [STAGES:0] vld_pipe;
    logic            adv;

    logic signed [A_WIDTH-1:0] s1_a;
    logic signed [B_WIDTH:0]   s1_op;
    logic signed [C_WIDTH-1:0] s1_c, s2_c;
    logic [3:0]                s1_mode, s2_mode;
    logic signed [M_WIDTH-1:0] s2_prod;

    logic signed [P_WIDTH-1:0] p_q, acc_q;
    logic signed [M_WIDTH-1:0] m_q;
    logic                      frame_last_q, overflow_q;
    logic [CNT_W-1:0]          cnt_q;

    logic signed [B_WIDTH:0]   b_x, d_x, pre, op;
    logic signed [M_WIDTH-1:0] a_x, op_x, prod;
    logic signed [P_WIDTH:0]   c_x, prod_x, acc_x, z, sum;
    logic                      sum_ovf, last_d;
    logic signed [P_WIDTH-1:0] res;

    // vld_pipe[0] is the incoming sample; upper bits are the stage valids
    assign vld_pipe = {vld_q, bus.in_valid};
    assign adv      = !vld_pipe[STAGES] || bus.out_ready;

    assign bus.in_ready   = adv;
    assign bus.out_valid  = vld_pipe[STAGES];
    assign bus.p          = p_q;
    assign bus.m          = m_q;
    assign bus.frame_last = frame_last_q;
    assign bus.overflow   = overflow_q;

    always_comb begin
        b_x = {bus.b[B_WIDTH-1], bus.b};
        d_x = {bus.d[B_WIDTH-1], bus.d};
        pre = bus.mode[0] ? (d_x - b_x) : (d_x + b_x);
        op  = bus.mode[1] ? pre : b_x;
    end

    always_comb begin
        a_x  = {{(M_WIDTH-A_WIDTH){s1_a[A_WIDTH-1]}}, s1_a};
        op_x = {{(M_WIDTH-B_WIDTH-1){s1_op[B_WIDTH]}}, s1_op};
        prod = a_x * op_x;
    end

    // One guard bit above P_WIDTH exposes overflow as a mismatch of the top two bits
    always_comb begin
        c_x    = {{(P_WIDTH+1-C_WIDTH){s2_c[C_WIDTH-1]}}, s2_c};
        prod_x = {{(P_WIDTH+1-M_WIDTH){s2_prod[M_WIDTH-1]}}, s2_prod};
        acc_x  = {acc_q[P_WIDTH-1], acc_q};
        if (cnt_q == '0) z = s2_mode[3] ? c_x : '0;
        else             z = acc_x;
        sum     = s2_mode[2] ? (z - prod_x) : (z + prod_x);
        sum_ovf = sum[P_WIDTH] ^ sum[P_WIDTH-1];
        if (sum_ovf && SATURATE) res = sum[P_WIDTH] ? P_MIN : P_MAX;
        else                     res = sum[P_WIDTH-1:0];
        last_d = (cnt_q == CNT_LAST);
    end

    // Datapath registers carry no reset; only the valid bits qualify them
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_a    <= bus.a;
            s1_op   <= op;
            s1_c    <= bus.c;
            s1_mode <= bus.mode;
            s2_prod <= prod;
            s2_c    <= s1_c;
            s2_mode <= s1_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q        <= '0;
            p_q          <= '0;
            m_q          <= '0;
            acc_q        <= '0;
            frame_last_q <= 1'b0;
            overflow_q   <= 1'b0;
            cnt_q        <= '0;
        end else if (adv) begin
            vld_q <= vld_pipe[STAGES-1:0];
            if (vld_pipe[STAGES-1]) begin
                p_q          <= res;
                acc_q        <= res;
                m_q          <= s2_prod;
                frame_last_q <= last_d;
                overflow_q   <= sum_ovf || ((cnt_q != '0) && overflow_q);
                cnt_q        <= last_d ? '0 : cnt_q + 1'b1;
            end
        end
    end
endmodule
